// File: rtl/pipe_mem_ctrl.sv
// pipe_mem_ctrl: arbitrates fetch/data misses onto one shared memory port and stalls the pipeline
module pipe_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        if_done,
  output logic        d_done,
  output logic [15:0] rdata,
  output logic        pc_wen,
  output logic        fd_wen,
  output logic        dx_wen,
  output logic        xm_wen,
  output logic        dx_flush,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, DONE, ERR} state_t;
  state_t      state, state_nx;
  logic [15:0] addr_q, wdata_q;
  logic        we_q, served_d, busy, run, mem_stall, fetch_stall;
  logic [3:0]  cnt;
  assign busy = (state == IBUSY) || (state == DBUSY);
  // next state: data wins in IDLE, no preemption while busy, timeout when the counter reaches 15
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = d_req ? DBUSY : (if_req ? IBUSY : IDLE);
      IBUSY, DBUSY: state_nx = mem_ready ? DONE : ((cnt >= 4'd14) ? ERR : state);
      DONE:        state_nx = IDLE;
      ERR:         state_nx = ERR;
      default:     state_nx = IDLE;
    endcase
  end
  // state register plus access capture, wait counter and read-data latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      served_d <= 1'b0;
      cnt      <= '0;
      rdata    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (d_req || if_req)) begin
        addr_q   <= d_req ? d_addr : if_addr;
        wdata_q  <= d_req ? d_wdata : wdata_q;
        we_q     <= d_req & d_we;
        served_d <= d_req;
        cnt      <= '0;
      end
      if (busy && !mem_ready) cnt <= (cnt == 4'hf) ? cnt : cnt + 4'd1;
      if (busy && mem_ready && !we_q) rdata <= mem_rdata;
    end
  end
  // memory strobes are gated by rst so an abort drops them without waiting for an edge
  always_comb begin
    mem_en      = rst & busy;
    mem_we      = rst & (state == DBUSY) & we_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    if_done     = rst & (state == DONE) & ~served_d;
    d_done      = rst & (state == DONE) & served_d;
    err         = rst & (state == ERR);
    run         = rst & (state != ERR);
    mem_stall   = d_req & ~d_done;
    fetch_stall = if_req & ~if_done;
    dx_wen      = run & ~mem_stall;
    xm_wen      = run & ~mem_stall;
    pc_wen      = run & ~mem_stall & ~fetch_stall;
    fd_wen      = run & ~mem_stall & ~fetch_stall;
    dx_flush    = run & fetch_stall & ~mem_stall;
  end
endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// tb_pipe_mem_ctrl: directed scenario bench for the shared-memory controller
module tb_pipe_mem_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        mem_en, mem_we, if_done, d_done, pc_wen, fd_wen, dx_wen, xm_wen, dx_flush, err;
  logic [15:0] mem_addr, mem_wdata, rdata;
  int pass = 0, total = 0;

  pipe_mem_ctrl dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_done(if_done), .d_done(d_done), .rdata(rdata), .pc_wen(pc_wen), .fd_wen(fd_wen),
    .dx_wen(dx_wen), .xm_wen(xm_wen), .dx_flush(dx_flush), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0) $display("FAIL rst_strobe got=%b%b exp=00", mem_en, mem_we); else pass++;
    total++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) $display("FAIL rst_bus got=%h/%h exp=0000/0000", mem_addr, mem_wdata); else pass++;
    total++; if ({if_done, d_done, err, dx_flush} !== 4'b0) $display("FAIL rst_flags got=%b exp=0000", {if_done, d_done, err, dx_flush}); else pass++;
    total++; if ({pc_wen, fd_wen, dx_wen, xm_wen} !== 4'b0) $display("FAIL rst_wen got=%b exp=0000", {pc_wen, fd_wen, dx_wen, xm_wen}); else pass++;
    total++; if (rdata !== 16'h0) $display("FAIL rst_rdata got=%h exp=0000", rdata); else pass++;
    tick;
    rst = 1'b1;
    tick;
    total++; if ({pc_wen, fd_wen, dx_wen, xm_wen} !== 4'b1111) $display("FAIL idle_wen got=%b exp=1111", {pc_wen, fd_wen, dx_wen, xm_wen}); else pass++;
  endtask

  task automatic test_fetch;
    if_req = 1'b1; if_addr = 16'h0040;
    #1;
    total++; if ({pc_wen, fd_wen, dx_flush, mem_en} !== 4'b0010) $display("FAIL fetch_idle got=%b exp=0010", {pc_wen, fd_wen, dx_flush, mem_en}); else pass++;
    tick;
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0040) $display("FAIL fetch_busy%0d got=%b%b/%h exp=10/0040", i, mem_en, mem_we, mem_addr); else pass++;
      total++; if ({pc_wen, fd_wen, dx_flush, if_done} !== 4'b0010) $display("FAIL fetch_stall%0d got=%b exp=0010", i, {pc_wen, fd_wen, dx_flush, if_done}); else pass++;
      if (i == 2) begin mem_ready = 1'b1; mem_rdata = 16'h1111; end
      tick;
    end
    mem_ready = 1'b0;
    total++; if (if_done !== 1'b1 || d_done !== 1'b0 || mem_en !== 1'b0) $display("FAIL fetch_done got=%b%b%b exp=100", if_done, d_done, mem_en); else pass++;
    total++; if (rdata !== 16'h1111) $display("FAIL fetch_rdata got=%h exp=1111", rdata); else pass++;
    total++; if ({pc_wen, dx_flush} !== 2'b10) $display("FAIL fetch_release got=%b exp=10", {pc_wen, dx_flush}); else pass++;
    if_req = 1'b0;
    tick;
    total++; if (if_done !== 1'b0) $display("FAIL fetch_pulse got=%b exp=0", if_done); else pass++;
  endtask

  task automatic test_priority;
    if_req = 1'b1; if_addr = 16'h0080;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
    tick;
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b1) $display("FAIL prio_strobe got=%b%b exp=11", mem_en, mem_we); else pass++;
    total++; if (mem_addr !== 16'h1234 || mem_wdata !== 16'hBEEF) $display("FAIL prio_bus got=%h/%h exp=1234/beef", mem_addr, mem_wdata); else pass++;
    mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    tick;
    mem_ready = 1'b0;
    total++; if (d_done !== 1'b1 || if_done !== 1'b0) $display("FAIL prio_ddone got=%b%b exp=10", d_done, if_done); else pass++;
    total++; if (rdata !== 16'h1111) $display("FAIL prio_wr_rdata got=%h exp=1111", rdata); else pass++;
    d_req = 1'b0; d_we = 1'b0;
    tick;
    total++; if (mem_en !== 1'b0) $display("FAIL prio_gap got=%b exp=0", mem_en); else pass++;
    tick;
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0080) $display("FAIL prio_fetch got=%b%b/%h exp=10/0080", mem_en, mem_we, mem_addr); else pass++;
    mem_ready = 1'b1; mem_rdata = 16'h2222;
    tick;
    mem_ready = 1'b0;
    total++; if (if_done !== 1'b1 || rdata !== 16'h2222) $display("FAIL prio_fdone got=%b/%h exp=1/2222", if_done, rdata); else pass++;
    if_req = 1'b0;
    tick;
  endtask

  task automatic test_dread;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    #1;
    total++; if ({pc_wen, fd_wen, dx_wen, xm_wen} !== 4'b0) $display("FAIL dread_idle_wen got=%b exp=0000", {pc_wen, fd_wen, dx_wen, xm_wen}); else pass++;
    tick;
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) $display("FAIL dread_busy got=%b%b/%h exp=10/0010", mem_en, mem_we, mem_addr); else pass++;
    total++; if ({pc_wen, fd_wen, dx_wen, xm_wen, dx_flush} !== 5'b0) $display("FAIL dread_wen got=%b exp=00000", {pc_wen, fd_wen, dx_wen, xm_wen, dx_flush}); else pass++;
    mem_ready = 1'b1; mem_rdata = 16'hA5A5;
    tick;
    mem_ready = 1'b0;
    total++; if (d_done !== 1'b1 || rdata !== 16'hA5A5) $display("FAIL dread_done got=%b/%h exp=1/a5a5", d_done, rdata); else pass++;
    total++; if ({pc_wen, fd_wen, dx_wen, xm_wen} !== 4'b1111) $display("FAIL dread_release got=%b exp=1111", {pc_wen, fd_wen, dx_wen, xm_wen}); else pass++;
    d_req = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    if_req = 1'b1; if_addr = 16'h0200;
    tick;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    #1;
    total++; if (mem_addr !== 16'h0200 || dx_wen !== 1'b0) $display("FAIL b2b_nopreempt got=%h/%b exp=0200/0", mem_addr, dx_wen); else pass++;
    tick;
    total++; if (mem_en !== 1'b1 || mem_addr !== 16'h0200 || mem_we !== 1'b0) $display("FAIL b2b_hold got=%b%b/%h exp=10/0200", mem_en, mem_we, mem_addr); else pass++;
    mem_ready = 1'b1; mem_rdata = 16'h3333;
    tick;
    mem_ready = 1'b0;
    total++; if (if_done !== 1'b1 || d_done !== 1'b0 || dx_wen !== 1'b0) $display("FAIL b2b_fdone got=%b%b%b exp=100", if_done, d_done, dx_wen); else pass++;
    if_req = 1'b0;
    tick;
    total++; if (mem_en !== 1'b0 || dx_wen !== 1'b0) $display("FAIL b2b_idle got=%b%b exp=00", mem_en, dx_wen); else pass++;
    tick;
    total++; if (mem_en !== 1'b1 || mem_addr !== 16'h0300 || dx_wen !== 1'b0) $display("FAIL b2b_dbusy got=%b/%h/%b exp=1/0300/0", mem_en, mem_addr, dx_wen); else pass++;
    mem_ready = 1'b1; mem_rdata = 16'h4444;
    tick;
    mem_ready = 1'b0;
    total++; if (d_done !== 1'b1 || rdata !== 16'h4444) $display("FAIL b2b_ddone got=%b/%h exp=1/4444", d_done, rdata); else pass++;
    d_req = 1'b0;
    tick;
  endtask

  task automatic test_timeout;
    int n = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
    tick;
    while (mem_en === 1'b1 && n < 40) begin
      n++;
      tick;
    end
    total++; if (n != 15) $display("FAIL to_cycles got=%0d exp=15", n); else pass++;
    total++; if (err !== 1'b1 || mem_en !== 1'b0) $display("FAIL to_err got=%b%b exp=10", err, mem_en); else pass++;
    d_req = 1'b0; if_req = 1'b1;
    repeat (4) tick;
    total++; if (err !== 1'b1 || {pc_wen, fd_wen, dx_wen, xm_wen, dx_flush} !== 5'b0) $display("FAIL to_sticky got=%b/%b exp=1/00000", err, {pc_wen, fd_wen, dx_wen, xm_wen, dx_flush}); else pass++;
    total++; if (if_done !== 1'b0 || mem_en !== 1'b0) $display("FAIL to_noaccess got=%b%b exp=00", if_done, mem_en); else pass++;
    if_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++; if (err !== 1'b0) $display("FAIL to_clear got=%b exp=0", err); else pass++;
    tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_reset_mid;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0060; d_wdata = 16'h7777;
    tick;
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b1) $display("FAIL rmid_busy got=%b%b exp=11", mem_en, mem_we); else pass++;
    #2 rst = 1'b0;
    #1;
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0) $display("FAIL rmid_async got=%b%b exp=00", mem_en, mem_we); else pass++;
    total++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || rdata !== 16'h0) $display("FAIL rmid_bus got=%h/%h/%h exp=0000/0000/0000", mem_addr, mem_wdata, rdata); else pass++;
    total++; if ({pc_wen, fd_wen, dx_wen, xm_wen, dx_flush, d_done} !== 6'b0) $display("FAIL rmid_outs got=%b exp=000000", {pc_wen, fd_wen, dx_wen, xm_wen, dx_flush, d_done}); else pass++;
    d_req = 1'b0; d_we = 1'b0;
    tick;
    rst = 1'b1; if_req = 1'b1; if_addr = 16'h0700;
    tick;
    total++; if (mem_en !== 1'b1 || mem_addr !== 16'h0700) $display("FAIL rmid_first got=%b/%h exp=1/0700", mem_en, mem_addr); else pass++;
    mem_ready = 1'b1; mem_rdata = 16'h5555;
    tick;
    mem_ready = 1'b0;
    total++; if (if_done !== 1'b1 || rdata !== 16'h5555) $display("FAIL rmid_done got=%b/%h exp=1/5555", if_done, rdata); else pass++;
    if_req = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_priority;
    test_dread;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/pipe_mem_ctrl.md
PIPE_MEM_CTRL -- requirements
Module: pipe_mem_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port if_req, input, 1: fetch-side miss needs the shared memory.
REQ-004 SHALL have port if_addr, input, 16: fetch address.
REQ-005 SHALL have port d_req, input, 1: data-side miss or write needs the shared memory.
REQ-006 SHALL have port d_we, input, 1: 1 = data write, 0 = data read.
REQ-007 SHALL have ports d_addr and d_wdata, input, 16 each: data address and write data.
REQ-008 SHALL have port mem_ready, input, 1: memory completes the current access this cycle.
REQ-009 SHALL have port mem_rdata, input, 16: memory read data, valid with mem_ready.
REQ-010 SHALL have ports mem_en and mem_we, output, 1 each: memory access strobe and write select.
REQ-011 SHALL have ports mem_addr and mem_wdata, output, 16 each: address and write data to memory.
REQ-012 SHALL have ports if_done and d_done, output, 1 each: one-cycle completion pulses.
REQ-013 SHALL have port rdata, output, 16: last read data returned.
REQ-014 SHALL have ports pc_wen, fd_wen, dx_wen and xm_wen, output, 1 each: write enables for the PC and the F/D, D/X and X/M pipeline registers.
REQ-015 SHALL have port dx_flush, output, 1: inject a bubble into D/X.
REQ-016 SHALL have port err, output, 1: sticky memory-timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, IBUSY, DBUSY, DONE and ERR.
REQ-018 IDLE: SHALL go to DBUSY if d_req=1; else to IBUSY if if_req=1; else stay in IDLE (data has priority on simultaneous requests).
REQ-019 On leaving IDLE, SHALL capture addr_q (d_addr or if_addr), plus wdata_q and we_q for data accesses, and clear the 4-bit wait counter.
REQ-020 IBUSY/DBUSY: mem_en=1, mem_addr=addr_q; mem_we=we_q in DBUSY, 0 in IBUSY; mem_wdata=wdata_q.
REQ-021 IBUSY/DBUSY: mem_ready=1 SHALL move the FSM to DONE; on reads, rdata SHALL latch mem_rdata on that edge.
REQ-022 Writes SHALL leave rdata unchanged.
REQ-023 An access in flight SHALL NOT be preempted: d_req arriving during IBUSY waits for that access to complete.
REQ-024 DONE: SHALL hold for exactly one cycle with if_done or d_done=1 for the access just served, ignore all requests, then return to IDLE.
REQ-025 Latency: request seen in IDLE at edge k -> mem_en from cycle k+1; mem_ready in cycle m -> done pulse in cycle m+1.
REQ-026 The wait counter SHALL increment each cycle in IBUSY/DBUSY without mem_ready, saturating at 15.
REQ-027 Count 15 reached without mem_ready SHALL move the FSM to ERR.
REQ-028 ERR: SHALL set err=1 and mem_en=0, drive all four wen outputs to 0, and leave ERR only on reset.
REQ-029 Combinational terms: mem_stall = d_req & ~d_done; fetch_stall = if_req & ~if_done.
REQ-030 Stall outputs: dx_wen = xm_wen = ~mem_stall; pc_wen = fd_wen = ~mem_stall & ~fetch_stall; dx_flush = fetch_stall & ~mem_stall.
REQ-031 REQ-030 SHALL apply only outside ERR and while rst=1.
REQ-032 mem_en and mem_we SHALL be 0 in IDLE, DONE and ERR.

Reset
REQ-033 While rst=0: state=IDLE; mem_en=mem_we=0; mem_addr=mem_wdata=0; if_done=d_done=0; rdata=0; err=0; counter=0; all wen=0; dx_flush=0.
REQ-034 Reset assertion mid-access SHALL abort the access, and mem_en SHALL fall without waiting for a clock edge.
REQ-035 After rst rises, the first request SHALL be taken at the next rising edge.

Verification
REQ-036 if_req=1, if_addr=0x0040, mem_ready after 3 busy cycles -> mem_en for 3 cycles at 0x0040, if_done one cycle later; pc_wen=fd_wen=0 and dx_flush=1 until if_done.
REQ-037 if_req and d_req rise together, d_we=1, d_addr=0x1234, d_wdata=0xBEEF -> data write served first (mem_we=1), d_done, then fetch served; rdata unchanged.
REQ-038 d_req read at 0x0010 with mem_rdata=0xA5A5 -> rdata=0xA5A5; all four wen=0 until the d_done pulse.
REQ-039 d_req rises during IBUSY -> fetch completes first; DBUSY starts after the DONE cycle; dx_wen=0 throughout.
REQ-040 mem_ready held 0 for 15 busy cycles -> err=1, mem_en=0, all wen=0; err stays 1 until rst=0.
REQ-041 rst=0 mid-DBUSY -> mem_en=0 immediately; all outputs at reset values; a new request after release is served normally.
